// File: rtl/adder_result_accum.sv
// Window accumulator for 4-bit adder results ({cout,sum}); sums WINDOW accepted samples
// and presents the total on a held valid/ready output with a sticky overflow flag.
module adder_result_accum #(
   parameter int  ACC_W  = 8,
   parameter int  WINDOW = 8,
   parameter int  SAT    = 1,
   localparam int CNT_W  = $clog2(WINDOW + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic             in_valid,
   input  logic [2:0]       in_sum,
   input  logic             in_cout,
   output logic             in_ready,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] out_total,
   output logic [CNT_W-1:0] out_count,
   output logic             out_ovf
);

   typedef enum logic {ACCUM, HOLD} state_t;

   state_t           state;
   state_t           state_next;
   logic [ACC_W-1:0] acc;
   logic [CNT_W-1:0] cnt;
   logic             ovf;
   logic [3:0]       v;
   logic             accept;
   logic             last;
   logic [ACC_W:0]   sum_ext;

   always_comb begin
      v       = {in_cout, in_sum};
      accept  = in_valid && (state == ACCUM);
      sum_ext = {1'b0, acc} + {{(ACC_W - 3){1'b0}}, v};
      last    = (cnt == CNT_W'(WINDOW - 1));
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= ACCUM;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      if (clear) begin
         state_next = ACCUM;
      end else begin
         case (state)
            ACCUM:   if (accept && last) state_next = HOLD;
            HOLD:    if (out_ready) state_next = ACCUM;
            default: state_next = ACCUM;
         endcase
      end
   end

   // Saturation sticks once overflow is seen, so later small samples cannot un-saturate.
   always_ff @(posedge clk) begin
      if (reset || clear) begin
         acc <= '0;
         cnt <= '0;
         ovf <= 1'b0;
      end else if (state == HOLD) begin
         if (out_ready) begin
            acc <= '0;
            cnt <= '0;
            ovf <= 1'b0;
         end
      end else if (accept) begin
         cnt <= cnt + 1'b1;
         if (sum_ext[ACC_W]) begin
            ovf <= 1'b1;
         end
         if ((SAT != 0) && (sum_ext[ACC_W] || ovf)) begin
            acc <= '1;
         end else begin
            acc <= sum_ext[ACC_W-1:0];
         end
      end
   end

   always_comb begin
      in_ready  = (state == ACCUM);
      out_valid = (state == HOLD);
      out_total = acc;
      out_count = cnt;
      out_ovf   = ovf;
   end

endmodule

// File: tb/tb_adder_result_accum.sv
// Self-checking bench for adder_result_accum: vector table, directed corner sequences,
// and randomized traffic compared against a queue-based window-sum reference model.
module tb_adder_result_accum;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset, clear, in_valid, in_cout, out_ready;
   logic [2:0] in_sum;

   logic       a_ir, a_ov, a_ovf;
   logic [7:0] a_total;
   logic [3:0] a_count;
   logic       s_ir, s_ov, s_ovf;
   logic [5:0] s_total;
   logic [3:0] s_count;
   logic       w_ir, w_ov, w_ovf;
   logic [5:0] w_total;
   logic [3:0] w_count;
   logic       o_ir, o_ov, o_ovf;
   logic [3:0] o_total;
   logic [0:0] o_count;

   adder_result_accum #(.ACC_W(8), .WINDOW(8), .SAT(1)) dut_a (
      .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .in_sum(in_sum),
      .in_cout(in_cout), .in_ready(a_ir), .out_valid(a_ov), .out_ready(out_ready),
      .out_total(a_total), .out_count(a_count), .out_ovf(a_ovf));

   adder_result_accum #(.ACC_W(6), .WINDOW(8), .SAT(1)) dut_s (
      .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .in_sum(in_sum),
      .in_cout(in_cout), .in_ready(s_ir), .out_valid(s_ov), .out_ready(out_ready),
      .out_total(s_total), .out_count(s_count), .out_ovf(s_ovf));

   adder_result_accum #(.ACC_W(6), .WINDOW(8), .SAT(0)) dut_w (
      .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .in_sum(in_sum),
      .in_cout(in_cout), .in_ready(w_ir), .out_valid(w_ov), .out_ready(out_ready),
      .out_total(w_total), .out_count(w_count), .out_ovf(w_ovf));

   adder_result_accum #(.ACC_W(4), .WINDOW(1), .SAT(1)) dut_o (
      .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .in_sum(in_sum),
      .in_cout(in_cout), .in_ready(o_ir), .out_valid(o_ov), .out_ready(out_ready),
      .out_total(o_total), .out_count(o_count), .out_ovf(o_ovf));

   int unsigned total_n = 0;
   int unsigned bad_n   = 0;

   typedef struct {
      bit          valid;
      bit [3:0]    v;
      bit          ordy;
      bit          clr;
      bit          e_ir;
      bit          e_ov;
      int unsigned e_tot;
      int unsigned e_cnt;
      bit          e_ovf;
   } vec_t;

   vec_t tbl[10];

   task automatic chk(input string name, input int unsigned act, input int unsigned exp);
      total_n++;
      if (act != exp) begin
         bad_n++;
         $display("FAIL %s got=%0d exp=%0d", name, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input bit valid, input logic [3:0] v);
      in_valid = valid;
      {in_cout, in_sum} = v;
   endtask

   task automatic chk_a(input string n, input bit ir, input bit ov, input int unsigned tot,
                        input int unsigned cnt, input bit ovf);
      chk({n, "_in_ready"}, a_ir, ir);
      chk({n, "_out_valid"}, a_ov, ov);
      chk({n, "_total"}, a_total, tot);
      chk({n, "_count"}, a_count, cnt);
      chk({n, "_ovf"}, a_ovf, ovf);
   endtask

   function automatic int unsigned ref_total(input int unsigned s, input int unsigned w,
                                             input bit sat);
      int unsigned mx = (1 << w) - 1;
      if (s <= mx) return s;
      return sat ? mx : (s % (mx + 1));
   endfunction

   int          m_q[$];
   bit          m_hold;
   int unsigned m_sum;
   int unsigned windows;
   int unsigned cyc;
   logic [3:0]  rv;

   initial begin
      reset = 1'b1; clear = 1'b0; out_ready = 1'b0;
      drive(1'b0, 4'd0);

      // reset with random inputs
      for (int i = 0; i < 2; i++) begin
         clear = 1'($urandom); out_ready = 1'($urandom);
         rv = 4'($urandom);
         drive(1'($urandom), rv);
         tick;
      end
      chk_a("reset", 1'b1, 1'b0, 0, 0, 1'b0);
      reset = 1'b0; clear = 1'b0; out_ready = 1'b0;
      drive(1'b0, 4'd0);
      tick;

      // table: eight samples of 3, then handshake, then a fresh window
      for (int i = 0; i < 8; i++) begin
         tbl[i] = '{1'b1, 4'd3, 1'b1, 1'b0, (i < 7), (i == 7), 3 * (i + 1), i + 1, 1'b0};
      end
      tbl[8] = '{1'b1, 4'd3, 1'b1, 1'b0, 1'b1, 1'b0, 0, 0, 1'b0};
      tbl[9] = '{1'b1, 4'd3, 1'b1, 1'b0, 1'b1, 1'b0, 3, 1, 1'b0};
      for (int i = 0; i < 10; i++) begin
         drive(tbl[i].valid, tbl[i].v);
         out_ready = tbl[i].ordy;
         clear = tbl[i].clr;
         tick;
         chk_a($sformatf("tbl%0d", i), tbl[i].e_ir, tbl[i].e_ov, tbl[i].e_tot, tbl[i].e_cnt,
               tbl[i].e_ovf);
      end
      clear = 1'b0;

      // overflow: eight samples of 15 into 6-bit saturating and wrapping instances
      reset = 1'b1; drive(1'b0, 4'd0); tick; reset = 1'b0;
      out_ready = 1'b0;
      for (int i = 0; i < 8; i++) begin
         drive(1'b1, 4'd15);
         tick;
      end
      chk("sat_total", s_total, 63);
      chk("sat_ovf", s_ovf, 1);
      chk("sat_valid", s_ov, 1);
      chk("wrap_total", w_total, 56);
      chk("wrap_ovf", w_ovf, 1);
      chk("wrap_count", w_count, 8);
      chk_a("wide", 1'b0, 1'b1, 120, 8, 1'b0);
      chk("w1_total", o_total, 15);
      chk("w1_count", o_count, 1);
      chk("w1_valid", o_ov, 1);
      chk("w1_in_ready", o_ir, 0);

      // backpressure while upstream keeps offering
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, 4'd9);
         tick;
         chk_a($sformatf("bp%0d", i), 1'b0, 1'b1, 120, 8, 1'b0);
      end
      out_ready = 1'b1; tick;
      chk_a("bp_release", 1'b1, 1'b0, 0, 0, 1'b0);
      chk("sat_ovf_cleared", s_ovf, 0);
      out_ready = 1'b0;
      for (int i = 0; i < 8; i++) begin
         drive(1'b1, 4'd2);
         tick;
      end
      chk_a("bp_next", 1'b0, 1'b1, 16, 8, 1'b0);
      out_ready = 1'b1; drive(1'b0, 4'd0); tick;
      out_ready = 1'b0;

      // clear drops the concurrent sample and restarts the window
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 4'd5);
         tick;
      end
      chk_a("pre_clear", 1'b1, 1'b0, 15, 3, 1'b0);
      clear = 1'b1; drive(1'b1, 4'd5); tick; clear = 1'b0;
      chk_a("clear", 1'b1, 1'b0, 0, 0, 1'b0);
      for (int i = 0; i < 8; i++) begin
         drive(1'b1, 4'd1);
         tick;
      end
      chk_a("after_clear", 1'b0, 1'b1, 8, 8, 1'b0);
      clear = 1'b1; out_ready = 1'b1; drive(1'b0, 4'd0); tick;
      clear = 1'b0; out_ready = 1'b0;
      chk_a("clear_hold", 1'b1, 1'b0, 0, 0, 1'b0);

      // reset during HOLD
      for (int i = 0; i < 8; i++) begin
         drive(1'b1, 4'd7);
         tick;
      end
      chk_a("pre_reset_hold", 1'b0, 1'b1, 56, 8, 1'b0);
      reset = 1'b1; tick; reset = 1'b0;
      chk_a("reset_hold", 1'b1, 1'b0, 0, 0, 1'b0);
      drive(1'b0, 4'd0); tick;

      // randomized traffic against the window-sum model
      m_q.delete(); m_hold = 1'b0; windows = 0; cyc = 0;
      while (windows < 1000 && cyc < 60000) begin
         rv = 4'($urandom_range(0, 15));
         drive(($urandom_range(0, 9) < 6), rv);
         out_ready = ($urandom_range(0, 2) != 0);
         clear = ($urandom_range(0, 63) == 0);
         if (clear) begin
            m_q.delete(); m_hold = 1'b0;
         end else if (m_hold) begin
            if (out_ready) begin
               m_q.delete(); m_hold = 1'b0; windows++;
            end
         end else if (in_valid) begin
            m_q.push_back(int'(rv));
            if (m_q.size() == 8) m_hold = 1'b1;
         end
         tick;
         cyc++;
         m_sum = 0;
         foreach (m_q[k]) m_sum += m_q[k];
         chk_a("rnd_a", !m_hold, m_hold, ref_total(m_sum, 8, 1'b1), m_q.size(), m_sum > 255);
         chk("rnd_s_total", s_total, ref_total(m_sum, 6, 1'b1));
         chk("rnd_s_ovf", s_ovf, m_sum > 63);
         chk("rnd_w_total", w_total, ref_total(m_sum, 6, 1'b0));
         chk("rnd_w_ovf", w_ovf, m_sum > 63);
         chk("rnd_w_valid", w_ov, m_hold);
      end
      clear = 1'b0;
      if (windows < 1000) chk("rnd_timeout_windows", windows, 1000);

      $display("test done: total=%0d bad=%0d", total_n, bad_n);
      $finish;
   end

endmodule
